// File: rtl/mfp_adc_max10_emu_pkg.sv
// Shared ADC definitions: data/channel widths, channel numbers and the
// emulator converter state encoding.
`default_nettype none
package mfp_adc_max10_emu_pkg;

    localparam int ADC_DATA_WIDTH          = 12;
    localparam int ADC_CH_WIDTH            = 5;
    localparam int ADC_CNT_WIDTH           = 8;
    localparam int ADC_CONV_CYCLES_DEFAULT = 4;

    localparam logic [ADC_CH_WIDTH-1:0] ADC_CH_TEMP  = 5'd0;
    localparam logic [ADC_CH_WIDTH-1:0] ADC_CH_POT   = 5'd1;
    localparam logic [ADC_CH_WIDTH-1:0] ADC_CH_LIGHT = 5'd3;
    localparam logic [ADC_CH_WIDTH-1:0] ADC_CH_AUX   = 5'd8;

    typedef enum logic {
        EMU_IDLE = 1'b0,
        EMU_BUSY = 1'b1
    } emu_conv_state_t;

endpackage
`default_nettype wire

// File: rtl/mfp_adc_emu_converter.sv
// Converter stage of the MAX10 ADC emulator: counts out one conversion,
// captures the sample on the finishing edge and emits a one-cycle response.
`default_nettype none
module mfp_adc_emu_converter
    import mfp_adc_max10_emu_pkg::*;
#(
    parameter int CONV_CYCLES = ADC_CONV_CYCLES_DEFAULT,
    parameter int DATA_WIDTH  = ADC_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    load_i,
    input  logic [ADC_CH_WIDTH-1:0] ch_i,
    input  logic                    sop_i,
    input  logic                    eop_i,
    input  logic [DATA_WIDTH-1:0]   sample_data_i,
    output logic                    idle_o,
    output logic                    finish_o,
    output logic                    r_valid_o,
    output logic [ADC_CH_WIDTH-1:0] r_ch_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic                    r_sop_o,
    output logic                    r_eop_o,
    output logic [ADC_CH_WIDTH-1:0] sample_ch_o
);

    localparam logic [ADC_CNT_WIDTH-1:0] CNT_LOAD = ADC_CNT_WIDTH'(CONV_CYCLES - 1);

    emu_conv_state_t           state_q, state_d;
    logic [ADC_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADC_CH_WIDTH-1:0]   ch_q, ch_d;
    logic                      sop_q, sop_d, eop_q, eop_d;
    logic                      r_valid_q, r_valid_d;
    logic [ADC_CH_WIDTH-1:0]   r_ch_q, r_ch_d;
    logic [DATA_WIDTH-1:0]     r_data_q, r_data_d;
    logic                      r_sop_q, r_sop_d, r_eop_q, r_eop_d;

    assign idle_o   = (state_q == EMU_IDLE);
    assign finish_o = (state_q == EMU_BUSY) && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= EMU_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_ch_q    <= '0;
            r_data_q  <= '0;
            r_sop_q   <= 1'b0;
            r_eop_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            r_valid_q <= r_valid_d;
            r_ch_q    <= r_ch_d;
            r_data_q  <= r_data_d;
            r_sop_q   <= r_sop_d;
            r_eop_q   <= r_eop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        r_valid_d = 1'b0;
        r_ch_d    = r_ch_q;
        r_data_d  = r_data_q;
        r_sop_d   = r_sop_q;
        r_eop_d   = r_eop_q;
        if (finish_o) begin
            r_valid_d = 1'b1;
            r_ch_d    = ch_q;
            r_data_d  = sample_data_i;
            r_sop_d   = sop_q;
            r_eop_d   = eop_q;
            state_d   = EMU_IDLE;
        end else if (state_q == EMU_BUSY) begin
            cnt_d = cnt_q - 1'b1;
        end
        // The top only asserts load when idle or finishing, so it may override the finish.
        if (load_i) begin
            state_d = EMU_BUSY;
            cnt_d   = CNT_LOAD;
            ch_d    = ch_i;
            sop_d   = sop_i;
            eop_d   = eop_i;
        end
    end

    assign r_valid_o   = r_valid_q;
    assign r_ch_o      = r_ch_q;
    assign r_data_o    = r_data_q;
    assign r_sop_o     = r_sop_q;
    assign r_eop_o     = r_eop_q;
    assign sample_ch_o = ch_q;

endmodule
`default_nettype wire

// File: rtl/mfp_adc_max10_emu.sv
// Synthesizable MAX10 modular ADC sequencer stand-in: one pending command slot,
// a fixed-latency converter, and start/end-of-sequence protocol checking.
`default_nettype none
module mfp_adc_max10_emu
    import mfp_adc_max10_emu_pkg::*;
#(
    parameter int CONV_CYCLES = ADC_CONV_CYCLES_DEFAULT,
    parameter int DATA_WIDTH  = ADC_DATA_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    ADC_C_Valid,
    input  logic [ADC_CH_WIDTH-1:0] ADC_C_Channel,
    input  logic                    ADC_C_SOP,
    input  logic                    ADC_C_EOP,
    output logic                    ADC_C_Ready,
    output logic                    ADC_R_Valid,
    output logic [ADC_CH_WIDTH-1:0] ADC_R_Channel,
    output logic [DATA_WIDTH-1:0]   ADC_R_Data,
    output logic                    ADC_R_SOP,
    output logic                    ADC_R_EOP,
    output logic [ADC_CH_WIDTH-1:0] SAMPLE_Channel,
    input  logic [DATA_WIDTH-1:0]   SAMPLE_Data,
    output logic                    PROTO_Error
);

    logic                    p_valid_q, p_valid_d;
    logic [ADC_CH_WIDTH-1:0] p_ch_q, p_ch_d;
    logic                    p_sop_q, p_sop_d, p_eop_q, p_eop_d;
    logic                    seq_open_q, seq_open_d;
    logic                    proto_err_q, proto_err_d;
    logic                    accept, load, conv_idle, conv_finish;

    assign ADC_C_Ready = ~p_valid_q;
    assign accept      = ADC_C_Valid & ~p_valid_q;
    assign load        = p_valid_q & (conv_idle | conv_finish);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            p_valid_q   <= 1'b0;
            p_ch_q      <= '0;
            p_sop_q     <= 1'b0;
            p_eop_q     <= 1'b0;
            seq_open_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            p_valid_q   <= p_valid_d;
            p_ch_q      <= p_ch_d;
            p_sop_q     <= p_sop_d;
            p_eop_q     <= p_eop_d;
            seq_open_q  <= seq_open_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        p_valid_d   = p_valid_q;
        p_ch_d      = p_ch_q;
        p_sop_d     = p_sop_q;
        p_eop_d     = p_eop_q;
        seq_open_d  = seq_open_q;
        proto_err_d = proto_err_q;
        // accept needs P empty and load needs P full, so they are mutually exclusive.
        if (load) begin
            p_valid_d = 1'b0;
        end
        if (accept) begin
            p_valid_d = 1'b1;
            p_ch_d    = ADC_C_Channel;
            p_sop_d   = ADC_C_SOP;
            p_eop_d   = ADC_C_EOP;
            if (ADC_C_SOP == seq_open_q) begin
                proto_err_d = 1'b1;
            end
            if (ADC_C_EOP) begin
                seq_open_d = 1'b0;
            end else if (ADC_C_SOP) begin
                seq_open_d = 1'b1;
            end
        end
    end

    assign PROTO_Error = proto_err_q;

    mfp_adc_emu_converter #(
        .CONV_CYCLES (CONV_CYCLES),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_converter (
        .clk_i         (CLK),
        .rst_n_i       (RESETn),
        .load_i        (load),
        .ch_i          (p_ch_q),
        .sop_i         (p_sop_q),
        .eop_i         (p_eop_q),
        .sample_data_i (SAMPLE_Data),
        .idle_o        (conv_idle),
        .finish_o      (conv_finish),
        .r_valid_o     (ADC_R_Valid),
        .r_ch_o        (ADC_R_Channel),
        .r_data_o      (ADC_R_Data),
        .r_sop_o       (ADC_R_SOP),
        .r_eop_o       (ADC_R_EOP),
        .sample_ch_o   (SAMPLE_Channel)
    );

endmodule
`default_nettype wire

// File: tb/tb_mfp_adc_max10_emu.sv
// Directed bench for mfp_adc_max10_emu: a CONV_CYCLES=4 instance for the main
// tests and a CONV_CYCLES=2 instance sharing the same stimulus for the boundary case.
`default_nettype none
module tb_mfp_adc_max10_emu;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        C_Valid = 1'b0;
    logic [4:0]  C_Channel = '0;
    logic        C_SOP = 1'b0;
    logic        C_EOP = 1'b0;
    logic [11:0] SAMPLE_Data;
    logic [11:0] sample_val = 12'h000;
    logic        track = 1'b0;

    logic        rdy4, rv4, rs4, re4, pe4;
    logic [4:0]  rc4, sc4;
    logic [11:0] rd4;
    logic        rdy2, rv2, rs2, re2, pe2;
    logic [4:0]  rc2, sc2;
    logic [11:0] rd2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [4:0] ch;
        logic [11:0] d;
        logic       sop;
        logic       eop;
    } resp_t;
    resp_t q4[$];
    resp_t q2[$];

    assign SAMPLE_Data = track ? (12'h100 + 12'(sc4)) : sample_val;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (rv4) q4.push_back('{cyc, rc4, rd4, rs4, re4});
        if (rv2) q2.push_back('{cyc, rc2, rd2, rs2, re2});
    end

    mfp_adc_max10_emu #(.CONV_CYCLES(4), .DATA_WIDTH(12)) dut4 (
        .CLK(CLK), .RESETn(RESETn), .ADC_C_Valid(C_Valid), .ADC_C_Channel(C_Channel),
        .ADC_C_SOP(C_SOP), .ADC_C_EOP(C_EOP), .ADC_C_Ready(rdy4), .ADC_R_Valid(rv4),
        .ADC_R_Channel(rc4), .ADC_R_Data(rd4), .ADC_R_SOP(rs4), .ADC_R_EOP(re4),
        .SAMPLE_Channel(sc4), .SAMPLE_Data(SAMPLE_Data), .PROTO_Error(pe4)
    );

    mfp_adc_max10_emu #(.CONV_CYCLES(2), .DATA_WIDTH(12)) dut2 (
        .CLK(CLK), .RESETn(RESETn), .ADC_C_Valid(C_Valid), .ADC_C_Channel(C_Channel),
        .ADC_C_SOP(C_SOP), .ADC_C_EOP(C_EOP), .ADC_C_Ready(rdy2), .ADC_R_Valid(rv2),
        .ADC_R_Channel(rc2), .ADC_R_Data(rd2), .ADC_R_SOP(rs2), .ADC_R_EOP(re2),
        .SAMPLE_Channel(sc2), .SAMPLE_Data(SAMPLE_Data), .PROTO_Error(pe2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        C_Valid = 1'b0;
        step();
        step();
        RESETn = 1'b1;
    endtask

    // Offer a command until accepted; returns edges taken and the accept-edge cycle.
    task automatic send(input logic [4:0] ch, input logic s, input logic e, input logic use2,
                        output int n, output int acc_cyc);
        logic rdy;
        C_Valid = 1'b1;
        C_Channel = ch;
        C_SOP = s;
        C_EOP = e;
        n = 0;
        do begin
            rdy = use2 ? rdy2 : rdy4;
            step();
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
        acc_cyc = cyc;
    endtask

    task automatic wait_rv4(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!rv4 && n < limit);
        if (!rv4) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, k, a0;

        // Reset state
        #2;
        chk("rst_ready", 32'(rdy4), 32'd1);
        chk("rst_rvalid", 32'(rv4), 32'd0);
        chk("rst_rch", 32'(rc4), 32'd0);
        chk("rst_rdata", 32'(rd4), 32'd0);
        chk("rst_rsop_reop", {30'd0, rs4, re4}, 32'd0);
        chk("rst_sample_ch", 32'(sc4), 32'd0);
        chk("rst_proto", 32'(pe4), 32'd0);
        step();
        RESETn = 1'b1;
        step();

        // Single command: accept E0, load E1, result after E5
        sample_val = 12'h5A3;
        send(5'd1, 1'b1, 1'b1, 1'b0, n, a0);
        C_Valid = 1'b0;
        chk("t1_ready_after_accept", 32'(rdy4), 32'd0);
        step();
        chk("t1_ready_after_load", 32'(rdy4), 32'd1);
        chk("t1_sample_ch", 32'(sc4), 32'd1);
        wait_rv4(20, k);
        chk("t1_latency", 32'(k + 1), 32'd5);
        chk("t1_rch", 32'(rc4), 32'd1);
        chk("t1_rdata", 32'(rd4), 32'h5A3);
        chk("t1_sop_eop", {30'd0, rs4, re4}, 32'd3);
        chk("t1_proto", 32'(pe4), 32'd0);
        step();
        chk("t1_pulse_single", 32'(rv4), 32'd0);
        chk("t1_data_hold", 32'(rd4), 32'h5A3);

        // Back-to-back sequence 0(SOP), 3, 8(EOP)
        q4.delete();
        track = 1'b1;
        send(5'd0, 1'b1, 1'b0, 1'b0, n, a0);
        send(5'd3, 1'b0, 1'b0, 1'b0, n, a0);
        send(5'd8, 1'b0, 1'b1, 1'b0, n, a0);
        C_Valid = 1'b0;
        chk("t2_third_wait", 32'(n <= 4), 32'd1);
        repeat (16) step();
        track = 1'b0;
        chk("t2_count", 32'(q4.size()), 32'd3);
        if (q4.size() == 3) begin
            chk("t2_d0", 32'(q4[0].d), 32'h100);
            chk("t2_d1", 32'(q4[1].d), 32'h103);
            chk("t2_d2", 32'(q4[2].d), 32'h108);
            chk("t2_gap01", 32'(q4[1].cyc - q4[0].cyc), 32'd4);
            chk("t2_gap12", 32'(q4[2].cyc - q4[1].cyc), 32'd4);
            chk("t2_sop", {29'd0, q4[0].sop, q4[1].sop, q4[2].sop}, 32'b100);
            chk("t2_eop", {29'd0, q4[0].eop, q4[1].eop, q4[2].eop}, 32'b001);
            chk("t2_ch2", 32'(q4[2].ch), 32'd8);
        end
        chk("t2_proto", 32'(pe4), 32'd0);

        // Sample capture: change one cycle before the finish edge
        sample_val = 12'h111;
        send(5'd2, 1'b1, 1'b1, 1'b0, n, a0);
        C_Valid = 1'b0;
        repeat (4) step();
        sample_val = 12'h222;
        step();
        chk("t3a_valid", 32'(rv4), 32'd1);
        chk("t3a_data", 32'(rd4), 32'h222);
        // Change just after the finish edge
        sample_val = 12'h111;
        send(5'd2, 1'b1, 1'b1, 1'b0, n, a0);
        C_Valid = 1'b0;
        repeat (5) step();
        sample_val = 12'h222;
        chk("t3b_valid", 32'(rv4), 32'd1);
        chk("t3b_data", 32'(rd4), 32'h111);
        step();

        // Protocol error A: first command without SOP
        do_reset();
        chk("t4a_proto_clear", 32'(pe4), 32'd0);
        sample_val = 12'h0C5;
        send(5'd5, 1'b0, 1'b0, 1'b0, n, a0);
        C_Valid = 1'b0;
        chk("t4a_proto_set", 32'(pe4), 32'd1);
        wait_rv4(20, k);
        chk("t4a_rch", 32'(rc4), 32'd5);
        chk("t4a_rdata", 32'(rd4), 32'h0C5);

        // Protocol error B: SOP then SOP again
        do_reset();
        send(5'd6, 1'b1, 1'b0, 1'b0, n, a0);
        chk("t4b_first_ok", 32'(pe4), 32'd0);
        send(5'd7, 1'b1, 1'b1, 1'b0, n, a0);
        C_Valid = 1'b0;
        chk("t4b_second_err", 32'(pe4), 32'd1);
        repeat (12) step();

        // Reset mid-conversion
        do_reset();
        sample_val = 12'h3CC;
        send(5'd9, 1'b1, 1'b1, 1'b0, n, a0);
        C_Valid = 1'b0;
        step();
        step();
        q4.delete();
        RESETn = 1'b0;
        #1;
        chk("t5_ready", 32'(rdy4), 32'd1);
        chk("t5_rvalid", 32'(rv4), 32'd0);
        chk("t5_rdata", 32'(rd4), 32'd0);
        chk("t5_rch", 32'(rc4), 32'd0);
        chk("t5_sample_ch", 32'(sc4), 32'd0);
        step();
        RESETn = 1'b1;
        repeat (10) step();
        chk("t5_no_resp", 32'(q4.size()), 32'd0);
        chk("t5_ready_after", 32'(rdy4), 32'd1);

        // CONV_CYCLES=2 boundary on dut2
        do_reset();
        q2.delete();
        sample_val = 12'h0AB;
        send(5'd4, 1'b1, 1'b1, 1'b1, n, a0);
        for (int i = 0; i < 3; i++) send(5'd4, 1'b1, 1'b1, 1'b1, n, k);
        C_Valid = 1'b0;
        repeat (10) step();
        chk("t6_count", 32'(q2.size()), 32'd4);
        if (q2.size() == 4) begin
            chk("t6_first_latency", 32'(q2[0].cyc - a0), 32'd3);
            for (int i = 1; i < 4; i++)
                chk($sformatf("t6_gap%0d", i), 32'(q2[i].cyc - q2[i-1].cyc), 32'd2);
            chk("t6_data", 32'(q2[3].d), 32'h0AB);
            chk("t6_ch", 32'(q2[0].ch), 32'd4);
        end
        chk("t6_proto", 32'(pe2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
